// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl: per-master bus access sequencer.
// Accepts one single-word read/write request from a core-side client,
// requests the shared bus from a round-robin arbiter, issues one address
// strobe, waits for the slave's ready (or a timeout), returns data/status
// to the client and releases the bus for one cycle. Every bus-side output
// is zero/inactive while the bus is not owned, so instances can be OR-muxed.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   core_as_         client request strobe (active-low, sampled in IDLE only)
//   core_rw          1 = read, 0 = write
//   core_addr        request word address
//   core_wr_data     write data
//   core_rd_data     read data, updated at done, held until the next done
//   core_done        one-cycle completion pulse
//   core_err         one-cycle timeout pulse, coincident with core_done
//   busy             high whenever the sequencer is not idle
//   bus_req_/bus_grnt_  arbiter request/grant (active-low)
//   bus_as_          bus address strobe (active-low)
//   bus_rw, bus_addr, bus_wr_data  bus command, driven only while owning the bus
//   bus_rd_data      slave read data
//   bus_rdy_         slave ready (active-low)
module bus_master_ctrl #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_as_,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_done,
    output logic              core_err,
    output logic              busy,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RELEASE} state_t;

    state_t            state, state_nxt;
    logic              lat_rw, lat_rw_nxt;
    logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
    logic [DATA_W-1:0] lat_wdata, lat_wdata_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic [DATA_W-1:0] core_rd_data_nxt;
    logic              core_done_nxt, core_err_nxt, busy_nxt;
    logic              bus_req_nxt, bus_as_nxt, bus_rw_nxt;
    logic [ADDR_W-1:0] bus_addr_nxt;
    logic [DATA_W-1:0] bus_wr_data_nxt;

    // State and all outputs are registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            lat_rw       <= 1'b1;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            cnt          <= '0;
            core_rd_data <= '0;
            core_done    <= 1'b0;
            core_err     <= 1'b0;
            busy         <= 1'b0;
            bus_req_     <= 1'b1;
            bus_as_      <= 1'b1;
            bus_rw       <= 1'b1;
            bus_addr     <= '0;
            bus_wr_data  <= '0;
        end else begin
            state        <= state_nxt;
            lat_rw       <= lat_rw_nxt;
            lat_addr     <= lat_addr_nxt;
            lat_wdata    <= lat_wdata_nxt;
            cnt          <= cnt_nxt;
            core_rd_data <= core_rd_data_nxt;
            core_done    <= core_done_nxt;
            core_err     <= core_err_nxt;
            busy         <= busy_nxt;
            bus_req_     <= bus_req_nxt;
            bus_as_      <= bus_as_nxt;
            bus_rw       <= bus_rw_nxt;
            bus_addr     <= bus_addr_nxt;
            bus_wr_data  <= bus_wr_data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (!core_as_) state_nxt = S_REQ;
            S_REQ:     if (!bus_grnt_) state_nxt = S_WAIT;
            S_WAIT:    if (!bus_rdy_ || cnt == CNT_MAX) state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Computes the values the registered outputs take on the next edge.
    // Bus command outputs default to inactive; only the REQ->WAIT edge and
    // WAIT cycles that stay in WAIT drive the latched command.
    always_comb begin
        lat_rw_nxt       = lat_rw;
        lat_addr_nxt     = lat_addr;
        lat_wdata_nxt    = lat_wdata;
        cnt_nxt          = cnt;
        core_rd_data_nxt = core_rd_data;
        core_done_nxt    = 1'b0;
        core_err_nxt     = 1'b0;
        busy_nxt         = (state_nxt != S_IDLE);
        bus_req_nxt      = 1'b1;
        bus_as_nxt       = 1'b1;
        bus_rw_nxt       = 1'b1;
        bus_addr_nxt     = '0;
        bus_wr_data_nxt  = '0;
        unique case (state)
            S_IDLE: begin
                if (!core_as_) begin
                    lat_rw_nxt    = core_rw;
                    lat_addr_nxt  = core_addr;
                    lat_wdata_nxt = core_wr_data;
                    bus_req_nxt   = 1'b0;
                end
            end
            S_REQ: begin
                bus_req_nxt = 1'b0;
                if (!bus_grnt_) begin
                    bus_as_nxt      = 1'b0;
                    bus_rw_nxt      = lat_rw;
                    bus_addr_nxt    = lat_addr;
                    bus_wr_data_nxt = lat_wdata;
                    cnt_nxt         = '0;
                end
            end
            S_WAIT: begin
                // Ready takes priority over a timeout in the same cycle.
                if (!bus_rdy_) begin
                    if (lat_rw) core_rd_data_nxt = bus_rd_data;
                    core_done_nxt = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    core_rd_data_nxt = '0;
                    core_done_nxt    = 1'b1;
                    core_err_nxt     = 1'b1;
                end else begin
                    cnt_nxt         = cnt + CNT_W'(1);
                    bus_req_nxt     = 1'b0;
                    bus_rw_nxt      = lat_rw;
                    bus_addr_nxt    = lat_addr;
                    bus_wr_data_nxt = lat_wdata;
                end
            end
            S_RELEASE: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bus_master_ctrl.sv
module tb_bus_master_ctrl;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_as_;
    logic        core_rw;
    logic [29:0] core_addr;
    logic [31:0] core_wr_data;
    logic [31:0] core_rd_data;
    logic        core_done;
    logic        core_err;
    logic        busy;
    logic        bus_req_;
    logic        bus_grnt_;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd = '0;

    bus_master_ctrl #(
        .ADDR_W(30),
        .DATA_W(32),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_as_(core_as_),
        .core_rw(core_rw),
        .core_addr(core_addr),
        .core_wr_data(core_wr_data),
        .core_rd_data(core_rd_data),
        .core_done(core_done),
        .core_err(core_err),
        .busy(busy),
        .bus_req_(bus_req_),
        .bus_grnt_(bus_grnt_),
        .bus_as_(bus_as_),
        .bus_rw(bus_rw),
        .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data),
        .bus_rdy_(bus_rdy_)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string where);
        check({where, " bus_req_"}, bus_req_, 1);
        check({where, " bus_as_"}, bus_as_, 1);
        check({where, " bus_rw"}, bus_rw, 1);
        check({where, " bus_addr"}, bus_addr, 0);
        check({where, " bus_wr_data"}, bus_wr_data, 0);
        check({where, " core_done"}, core_done, 0);
        check({where, " core_err"}, core_err, 0);
        check({where, " busy"}, busy, 0);
        check({where, " core_rd_data"}, core_rd_data, exp_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            core_as_    = 1'b1;
            bus_grnt_   = 1'($urandom_range(0, 1));
            bus_rdy_    = 1'($urandom_range(0, 1));
            bus_rd_data = $urandom;
            tick();
            check_idle("idle");
        end
    endtask

    // One transaction. Expected timing from request sample (cycle 0):
    // strobe at 2+gd, done at strobe + min(rd, TMO) + 1, timeout if rd > TMO.
    // gd = cycles the grant is withheld in REQ, rd = WAIT cycle index of rdy_.
    task automatic run_txn(input logic rw, input logic [29:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int gd, input int rd, input bit b2b, input int rst_at);
        int as_c, done_c, wlen;
        bit tmo, in_bus;
        logic [31:0] new_rd;
        tmo    = (rd > TMO);
        wlen   = tmo ? TMO : rd;
        as_c   = gd + 2;
        done_c = as_c + wlen + 1;
        new_rd = tmo ? 32'h0 : (rw ? rdata : exp_rd);

        core_as_     = 1'b0;
        core_rw      = rw;
        core_addr    = addr;
        core_wr_data = wdata;
        bus_grnt_    = (gd == 0) ? 1'b0 : 1'b1;
        bus_rdy_     = 1'b1;
        bus_rd_data  = $urandom;
        tick();

        for (int c = 1; c <= done_c + 1; c++) begin
            if (c == done_c) exp_rd = new_rd;
            in_bus = (c >= as_c && c < done_c);
            check("bus_req_", bus_req_, (c < done_c) ? 1'b0 : 1'b1);
            check("bus_as_", bus_as_, (c == as_c) ? 1'b0 : 1'b1);
            check("bus_addr", bus_addr, in_bus ? addr : 30'h0);
            check("bus_rw", bus_rw, in_bus ? rw : 1'b1);
            check("bus_wr_data", bus_wr_data, in_bus ? wdata : 32'h0);
            check("core_done", core_done, (c == done_c) ? 1'b1 : 1'b0);
            check("core_err", core_err, (c == done_c && tmo) ? 1'b1 : 1'b0);
            check("core_rd_data", core_rd_data, exp_rd);
            check("busy", busy, (c <= done_c) ? 1'b1 : 1'b0);
            if (c == done_c + 1) break;

            if (c == rst_at) begin
                #3;
                reset = 1'b0;
                #1;
                exp_rd = '0;
                check("async_rst", busy, 0);
                check_idle("async_rst");
                core_as_  = 1'b1;
                bus_grnt_ = 1'b0;
                bus_rdy_  = 1'b0;
                tick();
                check_idle("in_rst");
                #2;
                reset = 1'b1;
                bus_rdy_ = 1'b1;
                tick();
                check_idle("post_rst");
                return;
            end

            core_as_ = b2b ? 1'b0 : 1'($urandom_range(0, 1));
            if (c < as_c) begin
                bus_grnt_ = (c >= gd + 1) ? 1'b0 : 1'b1;
                bus_rdy_  = 1'($urandom_range(0, 1));
            end else if (c < done_c) begin
                bus_grnt_ = 1'($urandom_range(0, 1));
                bus_rdy_  = (c == as_c + rd) ? 1'b0 : 1'b1;
            end else begin
                bus_grnt_ = 1'($urandom_range(0, 1));
                bus_rdy_  = 1'($urandom_range(0, 1));
            end
            bus_rd_data = (c == as_c + rd) ? rdata : $urandom;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        core_as_     = 1'b1;
        core_rw      = 1'b1;
        core_addr    = '0;
        core_wr_data = '0;
        bus_grnt_    = 1'b1;
        bus_rd_data  = '0;
        bus_rdy_     = 1'b1;
        tick();
        tick();
        check_idle("reset");
        @(negedge clk);
        reset = 1'b1;
        tick();
        idle(2);

        // Immediate read: done 4 cycles after request.
        run_txn(1'b1, 30'h10, $urandom, 32'hDEADBEEF, 0, 1, 1'b0, -1);
        idle(1);
        // Grant withheld for 5 cycles, write leaves read data unchanged.
        run_txn(1'b0, 30'h3, 32'h12345678, $urandom, 5, 2, 1'b0, -1);
        idle(1);
        // Slave never ready: timeout clears read data.
        run_txn(1'b1, 30'($urandom), $urandom, $urandom, 1, TMO + 20, 1'b0, -1);
        idle(1);
        // Ready on the very cycle the counter reaches its limit.
        run_txn(1'b1, 30'($urandom), $urandom, 32'hA5A5_0F0F, 0, TMO, 1'b0, -1);
        idle(1);
        // Back-to-back with core_as_ held low throughout.
        run_txn(1'b1, 30'h1111, 32'h1, 32'hCAFE_0001, 0, 0, 1'b1, -1);
        run_txn(1'b0, 30'h2222, 32'h2, 32'hCAFE_0002, 2, 3, 1'b1, -1);
        run_txn(1'b1, 30'h3333, 32'h3, 32'hCAFE_0003, 1, TMO + 1, 1'b1, -1);
        idle(2);
        // Reset asserted in the middle of WAIT.
        run_txn(1'b1, 30'h55, 32'h66, 32'h77, 0, TMO + 20, 1'b0, 4);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), 30'($urandom), $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, TMO + 2),
                    1'($urandom_range(0, 1)), -1);
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
